// File: rtl/picomips_pkg.sv
// Shared picoMIPS types and sizes: program-counter width and sequencer states.
package picomips_pkg;

    localparam int unsigned PC_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WAIT_ASSERT,
        WAIT_RELEASE,
        HALT
    } pcs_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/memory-facing bundle of the program-flow controller.
interface pc_sequencer_if
    import picomips_pkg::*;
#(
    parameter int unsigned P_SIZE = PC_W
) ();

    logic              run;
    logic              halt_req;
    logic              wait_req;
    logic              in_valid;
    logic              jump_en;
    logic              branch_en;
    logic [P_SIZE-1:0] target;
    logic [P_SIZE-1:0] pc_out;
    logic              fetch_en;
    logic              waiting;
    logic              halted;

    // Decoder / environment side: issues requests, observes flow status.
    modport master (
        output run, halt_req, wait_req, in_valid, jump_en, branch_en, target,
        input  pc_out, fetch_en, waiting, halted
    );

    // Sequencer side.
    modport slave (
        input  run, halt_req, wait_req, in_valid, jump_en, branch_en, target,
        output pc_out, fetch_en, waiting, halted
    );

endinterface

// File: rtl/pc_next.sv
// Next-pc selection: absolute jump, relative branch (mod 2^P_SIZE) or increment.
module pc_next #(
    parameter int unsigned P_SIZE = 6
) (
    input  logic [P_SIZE-1:0] pc,
    input  logic [P_SIZE-1:0] target,
    input  logic              jump_en,
    input  logic              branch_en,
    output logic [P_SIZE-1:0] next_pc
);

    // An unsigned P_SIZE-bit add equals sign-extend-then-truncate of the offset.
    always_comb begin
        next_pc = pc + P_SIZE'(1);
        if (jump_en) begin
            next_pc = target;
        end else if (branch_en) begin
            next_pc = pc + target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// picoMIPS program-flow controller: owns the pc and sequences run/branch/wait/halt.
module pc_sequencer
    import picomips_pkg::*;
#(
    parameter int unsigned P_SIZE = PC_W
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    pcs_state_t        state_q;
    pcs_state_t        state_d;
    logic [P_SIZE-1:0] pc_d;
    logic [P_SIZE-1:0] pc_seq;
    logic              in_run;

    assign in_run = (state_q == RUN);

    // Decoder requests only steer the pc while running; elsewhere this yields pc+1.
    pc_next #(.P_SIZE(P_SIZE)) u_pc_next (
        .pc        (bus.pc_out),
        .target    (bus.target),
        .jump_en   (bus.jump_en && in_run),
        .branch_en (bus.branch_en && in_run),
        .next_pc   (pc_seq)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = bus.pc_out;
        unique case (state_q)
            IDLE: begin
                if (bus.run) state_d = RUN;
            end
            RUN: begin
                if (bus.halt_req) begin
                    state_d = HALT;
                end else if (bus.wait_req) begin
                    state_d = WAIT_ASSERT;
                end else begin
                    pc_d = pc_seq;
                end
            end
            WAIT_ASSERT: begin
                if (bus.in_valid) state_d = WAIT_RELEASE;
            end
            // Release completes the press: resume at the instruction after the wait.
            WAIT_RELEASE: begin
                if (!bus.in_valid) begin
                    state_d = RUN;
                    pc_d    = pc_seq;
                end
            end
            HALT: begin
                if (bus.run) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bus.pc_out   <= '0;
            bus.fetch_en <= 1'b0;
            bus.waiting  <= 1'b0;
            bus.halted   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus.pc_out   <= pc_d;
            bus.fetch_en <= (state_d == RUN);
            bus.waiting  <= (state_d == WAIT_ASSERT) || (state_d == WAIT_RELEASE);
            bus.halted   <= (state_d == HALT);
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-flow controller for the picoMIPS core. Owns the program counter register and sequences it: start, increment, relative branch, absolute jump, wait-for-input handshake, and halt. Sits between the instruction decoder, which supplies the control requests, and program memory, which takes pc_out and fetch_en.

Parameters:
P_SIZE, 6, program counter width; address space 2^P_SIZE instructions; also the branch offset width.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  start request; IDLE/HALT -> RUN
halt_req  input  1  decoder: current instruction is HALT
wait_req  input  1  decoder: current instruction waits for external input
in_valid  input  1  external input strobe (switch), already synchronised upstream
jump_en  input  1  decoder: absolute jump taken
branch_en  input  1  decoder: relative branch taken
target  input  P_SIZE  jump address (jump_en) or two's-complement offset (branch_en)
pc_out  output  P_SIZE  current program counter
fetch_en  output  1  instruction at pc_out is valid and executes this cycle
waiting  output  1  sequencer is in a wait-handshake state
halted  output  1  sequencer is in HALT

Behaviour:
- Reset is asynchronous, active-high and takes effect immediately, including mid-handshake. On reset: state=IDLE, pc_out=0, fetch_en=0, waiting=0, halted=0.
- States are IDLE, RUN, WAIT_ASSERT, WAIT_RELEASE and HALT.
- Outputs are decoded from registered state only (Moore):
  - fetch_en=1 only in RUN.
  - waiting=1 in WAIT_ASSERT and WAIT_RELEASE.
  - halted=1 in HALT.
- IDLE: pc held. run=1 -> RUN next cycle with pc unchanged, so the first fetch is at the current pc (0 after reset).
- RUN: exactly one action per cycle, chosen by fixed priority halt_req > wait_req > jump_en > branch_en > increment.
  - halt_req: -> HALT; pc held.
  - wait_req: -> WAIT_ASSERT; pc held.
  - jump_en: pc <= target.
  - branch_en: pc <= pc + sign-extended target, truncated to P_SIZE bits (mod 2^P_SIZE).
  - Otherwise: pc <= pc + 1, wrapping from 2^P_SIZE-1 to 0.
- WAIT_ASSERT: pc held; in_valid=1 -> WAIT_RELEASE. If in_valid is already 1 on entry, the transition happens on the next edge.
- WAIT_RELEASE: pc held; in_valid=0 -> RUN with pc <= pc+1, so execution resumes at the instruction after the wait. The press-then-release sequence guarantees one advance per button press.
- HALT: pc held. run=1 -> RUN with pc <= 0, which restarts the program.
- Decoder inputs (halt_req, wait_req, jump_en, branch_en, target) are ignored outside RUN.
- run is ignored in RUN and in both wait states.
- Latency: a control request sampled in RUN at edge N is visible on pc_out after edge N. There is no pipeline delay.

Decomposition:
- picomips_pkg:
  - typedef enum logic [2:0] pcs_state_t {IDLE, RUN, WAIT_ASSERT, WAIT_RELEASE, HALT}
  - localparam default PC width (6), shared with pc and program memory
- One combinational sub-module, pc_next, computes the next-pc value. Inputs: pc, target, jump_en, branch_en. Output: the priority mux of jump target, relative add (sign-extend plus truncate) and +1.
- The FSM and the pc register stay in pc_sequencer.

Test Plan:
1. Reset, then run=1 for 1 cycle, no requests for 5 cycles -> pc_out sequence 0,0,1,2,3,4; fetch_en=1 from the first RUN cycle.
2. pc=5, branch_en=1, target=6'b111101 (-3) -> pc=2. Then at pc=62, branch_en=1, target=4 -> pc=2 (wrap). Then pc=63 with no request -> pc=0.
3. pc=10, wait_req=1 -> WAIT_ASSERT, waiting=1, fetch_en=0, pc=10 held for 4 idle cycles. Then in_valid=1 for 3 cycles -> WAIT_RELEASE. Then in_valid=0 -> RUN, pc=11.
4. In RUN at pc=7, assert halt_req, wait_req, jump_en (target=20) and branch_en all together -> HALT with pc=7. Next, in RUN at pc=7, assert jump_en and branch_en together -> pc=20.
5. HALT at pc=33: jump_en=1 and target=9 are ignored and pc stays 33. Then run=1 -> RUN, pc=0.
6. In WAIT_RELEASE at pc=12, assert reset between clock edges -> pc_out=0 and state IDLE immediately, with no clock edge required. Deassert reset, run=1 -> RUN at pc=0.
